// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared definitions for the load/store unit controller.
// Holds the FSM state encoding, RV32 load/store opcodes, funct3 access
// encodings, the default bus timeout, and the access legality check.
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // 1 when the access is misaligned or uses a reserved funct3.
    function automatic logic access_err(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic err;
        err = 1'b1;
        case (funct3)
            F3_B:  err = 1'b0;
            F3_H:  err = addr_lo[0];
            F3_W:  err = (addr_lo != 2'b00);
            F3_BU: err = is_store;
            F3_HU: err = is_store | addr_lo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
// Ports:
//   funct3     - access size/sign encoding of the latched instruction
//   addr_lo    - byte offset within the word
//   wdata      - raw store data (rs2)
//   rdata      - bus read word
//   wstrb      - byte strobes for stores
//   wdata_lane - store data replicated across byte lanes
//   load_data  - extracted and sign/zero-extended load result
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                wstrb      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                wstrb      = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: begin
                wstrb      = 4'b1111;
                wdata_lane = wdata;
            end
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between the execute stage and a
// simple req/gnt/rvalid memory bus.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   req_valid/req_ready   - request handshake from execute (ready in IDLE)
//   inst, addr, wdata     - instruction word, effective address, store data
//   rsp_valid/err/rdata   - one-cycle completion pulse with result
//   mem_req/we/addr/wdata/wstrb - bus request side, word-aligned address
//   mem_gnt, mem_rvalid, mem_rdata - bus grant, completion and read data
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] inst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state, state_next;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [CNT_W-1:0] cnt;

    logic        is_load_op, is_store_op, accept, new_err;
    logic        in_bus, take_rsp, timeout, timeout_hit;
    logic [3:0]  strb;
    logic [31:0] wdata_lane, load_data;

    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst[31:15], inst[11:7]};

    lsu_align u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .wstrb      (strb),
        .wdata_lane (wdata_lane),
        .load_data  (load_data)
    );

    assign is_load_op  = (inst[6:0] == OP_LOAD);
    assign is_store_op = (inst[6:0] == OP_STORE);
    assign accept      = (state == ST_IDLE) && req_valid && (is_load_op || is_store_op);
    assign new_err     = access_err(is_store_op, inst[14:12], addr[1:0]);

    // rvalid only counts once the request has been granted; a same-cycle
    // gnt+rvalid in REQ completes directly.
    assign in_bus      = (state == ST_REQ) || (state == ST_WAIT);
    assign take_rsp    = ((state == ST_REQ) && mem_gnt && mem_rvalid) ||
                         ((state == ST_WAIT) && mem_rvalid);
    assign timeout     = (cnt == CNT_LAST);
    assign timeout_hit = in_bus && !take_rsp && timeout;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = new_err ? ST_RESP : ST_REQ;
            ST_REQ: begin
                if (take_rsp || timeout)  state_next = ST_RESP;
                else if (mem_gnt)         state_next = ST_WAIT;
            end
            ST_WAIT: if (take_rsp || timeout) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            cnt        <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                is_store_q <= is_store_op;
                funct3_q   <= inst[14:12];
                addr_q     <= addr;
                wdata_q    <= wdata;
                err_q      <= new_err;
                rdata_q    <= '0;
                cnt        <= '0;
            end else if (in_bus) begin
                cnt <= cnt + 1'b1;
                if (timeout_hit)
                    err_q <= 1'b1;
                if (take_rsp && !is_store_q)
                    rdata_q <= load_data;
            end
        end
    end

    assign req_ready = rst_n && (state == ST_IDLE);
    assign mem_req   = (state == ST_REQ);
    assign mem_we    = mem_req && is_store_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_lane;
    assign mem_wstrb = is_store_q ? strb : '0;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl (TIMEOUT_CYCLES=4).
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] inst, addr, wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] I_LW   = 32'h0000_2003;
    localparam logic [31:0] I_LB   = 32'h0000_0003;
    localparam logic [31:0] I_LH   = 32'h0000_1003;
    localparam logic [31:0] I_LBU  = 32'h0000_4003;
    localparam logic [31:0] I_LHU  = 32'h0000_5003;
    localparam logic [31:0] I_LRSV = 32'h0000_3003;
    localparam logic [31:0] I_SB   = 32'h0000_0023;
    localparam logic [31:0] I_SH   = 32'h0000_1023;
    localparam logic [31:0] I_SW   = 32'h0000_2023;
    localparam logic [31:0] I_SRSV = 32'h0000_3023;
    localparam logic [31:0] I_ADDI = 32'h0000_0013;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .inst       (inst),
        .addr       (addr),
        .wdata      (wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Accept, then grant and complete in the same REQ cycle; samples the
    // bus side in REQ and the response one cycle later.
    task automatic bus_imm(input logic [31:0] i, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           output logic [31:0] o_req, output logic [31:0] o_we,
                           output logic [31:0] o_addr, output logic [31:0] o_wdata,
                           output logic [31:0] o_strb, output logic [31:0] o_valid,
                           output logic [31:0] o_err, output logic [31:0] o_rdata);
        req_valid = 1'b1; inst = i; addr = a; wdata = wd;
        next_cycle();
        req_valid = 1'b0; inst = '0; addr = '0; wdata = '0;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = rd;
        #1;
        o_req   = {31'b0, mem_req};
        o_we    = {31'b0, mem_we};
        o_addr  = mem_addr;
        o_wdata = mem_wdata;
        o_strb  = {28'b0, mem_wstrb};
        next_cycle();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        o_valid = {31'b0, rsp_valid};
        o_err   = {31'b0, rsp_err};
        o_rdata = rsp_rdata;
        next_cycle();
    endtask

    // Accept an access expected to fail immediately; sample the next cycle.
    task automatic err_acc(input logic [31:0] i, input logic [31:0] a,
                           output logic [31:0] o_req, output logic [31:0] o_valid,
                           output logic [31:0] o_err, output logic [31:0] o_rdata);
        req_valid = 1'b1; inst = i; addr = a; wdata = 32'h5555_AAAA;
        next_cycle();
        req_valid = 1'b0; inst = '0; addr = '0; wdata = '0;
        #1;
        o_req   = {31'b0, mem_req};
        o_valid = {31'b0, rsp_valid};
        o_err   = {31'b0, rsp_err};
        o_rdata = rsp_rdata;
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g_req, g_we, g_addr, g_wdata, g_strb, g_valid, g_err, g_rdata;

        rst_n = 1'b0; req_valid = 1'b0; inst = '0; addr = '0; wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset
        next_cycle(); next_cycle();
        #1;
        check("ready_in_reset", {31'b0, req_ready}, 32'd0);
        check("mem_req_in_reset", {31'b0, mem_req}, 32'd0);
        rst_n = 1'b1;
        next_cycle();
        #1;
        check("ready_after_reset", {31'b0, req_ready}, 32'd1);
        check("rsp_valid_after_reset", {31'b0, rsp_valid}, 32'd0);
        check("mem_addr_after_reset", mem_addr, 32'h0);
        check("mem_wstrb_after_reset", {28'b0, mem_wstrb}, 32'h0);
        check("mem_wdata_after_reset", mem_wdata, 32'h0);

        // lw via REQ -> WAIT -> RESP
        next_cycle();
        req_valid = 1'b1; inst = I_LW; addr = 32'h8000_0004;
        #1;
        check("lw_c0_ready", {31'b0, req_ready}, 32'd1);
        next_cycle();
        req_valid = 1'b0; inst = '0; addr = '0; mem_gnt = 1'b1;
        #1;
        check("lw_c1_req", {31'b0, mem_req}, 32'd1);
        check("lw_c1_addr", mem_addr, 32'h8000_0004);
        check("lw_c1_we", {31'b0, mem_we}, 32'd0);
        check("lw_c1_ready", {31'b0, req_ready}, 32'd0);
        next_cycle();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("lw_c2_req", {31'b0, mem_req}, 32'd0);
        check("lw_c2_valid", {31'b0, rsp_valid}, 32'd0);
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        check("lw_c3_valid", {31'b0, rsp_valid}, 32'd1);
        check("lw_c3_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("lw_c3_err", {31'b0, rsp_err}, 32'd0);
        next_cycle();
        #1;
        check("lw_c4_valid", {31'b0, rsp_valid}, 32'd0);
        check("lw_c4_ready", {31'b0, req_ready}, 32'd1);
        next_cycle();

        // Loads with same-cycle gnt+rvalid
        bus_imm(I_LB, 32'h8000_0003, 32'h0, 32'h8012_3456,
                g_req, g_we, g_addr, g_wdata, g_strb, g_valid, g_err, g_rdata);
        check("lb_req", g_req, 32'd1);
        check("lb_addr", g_addr, 32'h8000_0000);
        check("lb_valid", g_valid, 32'd1);
        check("lb_rdata", g_rdata, 32'hFFFF_FF80);

        bus_imm(I_LBU, 32'h8000_0003, 32'h0, 32'h8012_3456,
                g_req, g_we, g_addr, g_wdata, g_strb, g_valid, g_err, g_rdata);
        check("lbu_rdata", g_rdata, 32'h0000_0080);
        check("lbu_err", g_err, 32'd0);

        bus_imm(I_LH, 32'h8000_0002, 32'h0, 32'h8001_7FFF,
                g_req, g_we, g_addr, g_wdata, g_strb, g_valid, g_err, g_rdata);
        check("lh_rdata", g_rdata, 32'hFFFF_8001);

        bus_imm(I_LHU, 32'h8000_0000, 32'h0, 32'h1234_F00D,
                g_req, g_we, g_addr, g_wdata, g_strb, g_valid, g_err, g_rdata);
        check("lhu_rdata", g_rdata, 32'h0000_F00D);

        // Stores
        bus_imm(I_SH, 32'h8000_0002, 32'h0000_ABCD, 32'h1111_1111,
                g_req, g_we, g_addr, g_wdata, g_strb, g_valid, g_err, g_rdata);
        check("sh_we", g_we, 32'd1);
        check("sh_strb", g_strb, 32'hC);
        check("sh_wdata", g_wdata, 32'hABCD_ABCD);
        check("sh_addr", g_addr, 32'h8000_0000);
        check("sh_rdata", g_rdata, 32'h0);
        check("sh_valid", g_valid, 32'd1);

        bus_imm(I_SB, 32'h8000_0001, 32'h1234_5678, 32'h1111_1111,
                g_req, g_we, g_addr, g_wdata, g_strb, g_valid, g_err, g_rdata);
        check("sb_strb", g_strb, 32'h2);
        check("sb_wdata", g_wdata, 32'h7878_7878);

        bus_imm(I_SW, 32'h8000_0008, 32'hCAFE_F00D, 32'h1111_1111,
                g_req, g_we, g_addr, g_wdata, g_strb, g_valid, g_err, g_rdata);
        check("sw_strb", g_strb, 32'hF);
        check("sw_wdata", g_wdata, 32'hCAFE_F00D);
        check("sw_addr", g_addr, 32'h8000_0008);
        check("sw_rdata", g_rdata, 32'h0);

        // Error path: misaligned and reserved funct3
        err_acc(I_LW, 32'h8000_0001, g_req, g_valid, g_err, g_rdata);
        check("lw_mis_req", g_req, 32'd0);
        check("lw_mis_valid", g_valid, 32'd1);
        check("lw_mis_err", g_err, 32'd1);
        check("lw_mis_rdata", g_rdata, 32'h0);

        err_acc(I_LH, 32'h8000_0003, g_req, g_valid, g_err, g_rdata);
        check("lh_mis_err", g_err, 32'd1);
        err_acc(I_SH, 32'h8000_0001, g_req, g_valid, g_err, g_rdata);
        check("sh_mis_err", g_err, 32'd1);
        check("sh_mis_req", g_req, 32'd0);
        err_acc(I_LRSV, 32'h8000_0000, g_req, g_valid, g_err, g_rdata);
        check("ld_rsv_err", g_err, 32'd1);
        err_acc(I_SRSV, 32'h8000_0000, g_req, g_valid, g_err, g_rdata);
        check("st_rsv_err", g_err, 32'd1);

        // Non-memory opcode is ignored; stray rvalid in IDLE is ignored
        req_valid = 1'b1; inst = I_ADDI; addr = 32'h8000_0000;
        next_cycle();
        req_valid = 1'b0; inst = '0; addr = '0; mem_rvalid = 1'b1;
        #1;
        check("addi_ready", {31'b0, req_ready}, 32'd1);
        check("addi_mem_req", {31'b0, mem_req}, 32'd0);
        next_cycle();
        mem_rvalid = 1'b0;
        #1;
        check("idle_rvalid_valid", {31'b0, rsp_valid}, 32'd0);
        next_cycle();

        // Timeout with gnt held low
        req_valid = 1'b1; inst = I_LW; addr = 32'h8000_0010;
        next_cycle();
        req_valid = 1'b0; inst = '0; addr = '0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("to_req_held", {31'b0, mem_req}, 32'd1);
            check("to_no_rsp", {31'b0, rsp_valid}, 32'd0);
            next_cycle();
        end
        #1;
        check("to_req_dropped", {31'b0, mem_req}, 32'd0);
        check("to_valid", {31'b0, rsp_valid}, 32'd1);
        check("to_err", {31'b0, rsp_err}, 32'd1);
        check("to_rdata", rsp_rdata, 32'h0);
        next_cycle();

        // Reset while in WAIT, then a late rvalid
        req_valid = 1'b1; inst = I_LW; addr = 32'h8000_0020;
        next_cycle();
        req_valid = 1'b0; inst = '0; addr = '0; mem_gnt = 1'b1;
        next_cycle();
        mem_gnt = 1'b0;
        #1;
        check("rw_wait_req", {31'b0, mem_req}, 32'd0);
        check("rw_wait_valid", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b0;
        next_cycle();
        #1;
        check("rw_ready_in_reset", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        check("rw_ready_after", {31'b0, req_ready}, 32'd1);
        check("rw_no_rsp_a", {31'b0, rsp_valid}, 32'd0);
        check("rw_mem_addr_cleared", mem_addr, 32'h0);
        next_cycle();
        #1;
        check("rw_no_rsp_b", {31'b0, rsp_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
